// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down modulo counter and its prescaler.
package counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam int DEFAULT_WIDTH        = 8;
    localparam int DEFAULT_PRESCALE_DIV = 4;

    // Prescaler phase counter width; a divide-by-1 still needs one bit.
    function automatic int prescale_width(input int div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enabled-cycle prescaler: tick is high while the phase sits at PRESCALE_DIV-1.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE_DIV = DEFAULT_PRESCALE_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int              PW   = prescale_width(PRESCALE_DIV);
    localparam logic [PW-1:0]   LAST = PW'(PRESCALE_DIV - 1);

    logic [PW-1:0] phase_reg;

    assign tick = (phase_reg == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_reg <= '0;
        end else if (clr) begin
            phase_reg <= '0;
        end else if (en) begin
            phase_reg <= tick ? '0 : phase_reg + 1'b1;
        end
    end

endmodule

// File: rtl/counter_updown_mod.sv
// WIDTH-bit up/down modulo counter with load, clear, tc pulse and sticky wrap flag.
// Optional enabled-cycle prescaler under COUNTER_PRESCALE_EN.
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int PRESCALE_DIV = DEFAULT_PRESCALE_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrapped
);

    logic [WIDTH-1:0] q_reg, q_next;
    logic             tc_reg, tc_next;
    logic             wrapped_reg, wrapped_next;
    logic             tick;

`ifdef COUNTER_PRESCALE_EN
    // Load restarts the prescaler phase as well as clear does.
    counter_prescaler #(
        .PRESCALE_DIV(PRESCALE_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr | load),
        .en   (en),
        .tick (tick)
    );
`else
    // Every enabled cycle advances; PRESCALE_DIV is referenced only to keep the parameter live.
    assign tick = (PRESCALE_DIV >= 1) | 1'b1;
`endif

    always_comb begin
        q_next       = q_reg;
        tc_next      = 1'b0;
        wrapped_next = wrapped_reg;
        if (clr) begin
            q_next       = '0;
            wrapped_next = 1'b0;
        end else if (load) begin
            q_next = d;
        end else if (en && tick) begin
            if (up_dn == DIR_UP) begin
                if (q_reg >= max_val) begin
                    q_next       = '0;
                    tc_next      = 1'b1;
                    wrapped_next = 1'b1;
                end else begin
                    q_next = q_reg + 1'b1;
                end
            end else begin
                if (q_reg == '0) begin
                    q_next       = max_val;
                    tc_next      = 1'b1;
                    wrapped_next = 1'b1;
                end else begin
                    q_next = q_reg - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg       <= '0;
            tc_reg      <= 1'b0;
            wrapped_reg <= 1'b0;
        end else begin
            q_reg       <= q_next;
            tc_reg      <= tc_next;
            wrapped_reg <= wrapped_next;
        end
    end

    assign q       = q_reg;
    assign tc      = tc_reg;
    assign wrapped = wrapped_reg;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Self-checking bench for counter_updown_mod: directed steps plus random traffic against a reference model.
module tb_counter_updown_mod;

    localparam int WIDTH = 8;
    localparam int DIV   = 4;
`ifdef COUNTER_PRESCALE_EN
    localparam int PDIV  = DIV;
`else
    localparam int PDIV  = 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clr = 1'b0;
    logic             en = 1'b0;
    logic             up_dn = 1'b1;
    logic             load = 1'b0;
    logic [WIDTH-1:0] d = '0;
    logic [WIDTH-1:0] max_val = '0;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrapped;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference state: count value, terminal pulse, sticky flag, enabled-cycle phase.
    int m_q, m_ph;
    bit m_tc, m_wr;

    counter_updown_mod #(
        .WIDTH       (WIDTH),
        .PRESCALE_DIV(DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .en      (en),
        .up_dn   (up_dn),
        .load    (load),
        .d       (d),
        .max_val (max_val),
        .q       (q),
        .tc      (tc),
        .wrapped (wrapped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_q = 0; m_tc = 0; m_wr = 0; m_ph = 0;
    endtask

    task automatic model_edge();
        int mv;
        mv   = int'(max_val);
        m_tc = 0;
        if (clr) begin
            m_q = 0; m_wr = 0; m_ph = 0;
        end else if (load) begin
            m_q = int'(d); m_ph = 0;
        end else if (en) begin
            if (m_ph == PDIV - 1) begin
                m_ph = 0;
                if (up_dn) begin
                    if (m_q >= mv) begin m_q = 0; m_tc = 1; m_wr = 1; end
                    else m_q = m_q + 1;
                end else begin
                    if (m_q == 0) begin m_q = mv; m_tc = 1; m_wr = 1; end
                    else m_q = m_q - 1;
                end
            end else begin
                m_ph = m_ph + 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".q"}, 32'(q), 32'(m_q));
        chk({tag, ".tc"}, 32'(tc), 32'(m_tc));
        chk({tag, ".wrapped"}, 32'(wrapped), 32'(m_wr));
    endtask

    // One clock edge: model follows the inputs present at the edge, outputs sampled 1ns later.
    task automatic step(input string tag);
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        $display("cyc=%0d %s clr=%0b ld=%0b en=%0b up=%0b d=%0h max=%0h -> q=%0h tc=%0b wr=%0b",
                 cyc, tag, clr, load, en, up_dn, d, max_val, q, tc, wrapped);
        check_all(tag);
    endtask

    task automatic set_in(input logic c, input logic l, input logic e, input logic u,
                          input logic [WIDTH-1:0] dv, input logic [WIDTH-1:0] mv);
        clr = c; load = l; en = e; up_dn = u; d = dv; max_val = mv;
    endtask

    int last_tc, gap, hold_q;

    initial begin
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b0;

        // Count up to 0x37 with a wide limit, then assert rst between edges.
        set_in(0, 0, 1, 1, 8'h00, 8'hFF);
        for (int i = 0; i < 8'h37 * PDIV; i++) step("run_up");
        chk("mid_count_q", 32'(q), 32'h37);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        rst = 1'b0;

        // Load beats enable.
        set_in(0, 1, 1, 1, 8'hA5, 8'hFF);
        step("load_a5");
        chk("load_value", 32'(q), 32'hA5);

        // Up modulo 10 from zero; tc period M+1 advances.
        set_in(1, 0, 0, 1, 8'h00, 8'd9);
        step("clr");
        set_in(0, 0, 1, 1, 8'h00, 8'd9);
        last_tc = -1;
        for (int i = 0; i < 25 * PDIV; i++) begin
            step("up_mod10");
            if (tc) begin
                if (last_tc >= 0) begin
                    gap = cyc - last_tc;
                    chk("tc_period", 32'(gap), 32'(10 * PDIV));
                end
                last_tc = cyc;
            end
        end

        // Down wrap at max 5, then out-of-range load counted up.
        set_in(1, 0, 0, 0, 8'h00, 8'd5);
        step("clr");
        set_in(0, 0, 1, 0, 8'h00, 8'd5);
        for (int i = 0; i < 3 * PDIV; i++) step("down_wrap");
        set_in(0, 1, 0, 1, 8'd12, 8'd5);
        step("load_12");
        set_in(0, 0, 1, 1, 8'd12, 8'd5);
        for (int i = 0; i < PDIV; i++) step("up_from_12");
        chk("oor_wrap_q", 32'(q), 32'd0);
        chk("oor_wrap_tc", 32'(tc), 32'd1);

        // Clear beats load and enable.
        set_in(1, 1, 1, 1, 8'h44, 8'd9);
        step("clr_prio");
        // Hold with en low.
        set_in(0, 1, 0, 1, 8'd3, 8'd9);
        step("load_3");
        set_in(0, 0, 0, 1, 8'd3, 8'd9);
        hold_q = int'(q);
        for (int i = 0; i < 5; i++) begin
            step("hold");
            chk("hold_q", 32'(q), 32'(hold_q));
        end
        // Direction flip at q=3.
        set_in(0, 0, 1, 0, 8'd3, 8'd9);
        for (int i = 0; i < 2 * PDIV; i++) step("flip_dn");
        chk("flip_q", 32'(q), 32'd1);

        // max_val = 0 in both directions.
        set_in(0, 0, 1, 1, 8'd0, 8'd0);
        for (int i = 0; i < 3 * PDIV; i++) step("max0_up");
        set_in(0, 0, 1, 0, 8'd0, 8'd0);
        for (int i = 0; i < 3 * PDIV; i++) step("max0_dn");

        // Random traffic including occasional async reset pulses between edges.
        for (int i = 0; i < 400; i++) begin
            clr     = ($urandom_range(0, 29) == 0);
            load    = ($urandom_range(0, 14) == 0);
            en      = ($urandom_range(0, 3) != 0);
            up_dn   = $urandom_range(0, 1);
            d       = WIDTH'($urandom);
            if ($urandom_range(0, 19) == 0)
                max_val = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom_range(0, 12)) : WIDTH'($urandom);
            step("rand");
            if ($urandom_range(0, 79) == 0) begin
                rst = 1'b1;
                #2;
                model_reset();
                check_all("rand_rst");
                rst = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout simulation did not finish observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
